// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between fetch, data stage and the reset/interrupt vector reads.
// Latency: zero; grants and memory controls are combinational from state and requests. Optional macro ARB_FAIR_EN.
// Backpressure: a request that loses sees no grant (if_stall / pipeline holds at MEM); ARB_FAIR_EN caps DM streaks.
module mem_port_arbiter #(
    parameter int ADDR_W        = 8,
    parameter int DATA_W        = 8,
    parameter int RST_VEC_ADDR  = 0,
    parameter int INT_VEC_ADDR  = 1,
    parameter int MAX_DM_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    input  logic              ivec_req,
    output logic              ivec_ack,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_vec,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        RVEC = 2'd0,
        RUN  = 2'd1,
        IVEC = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   fair_force;

`ifdef ARB_FAIR_EN
    localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);

    logic [STREAK_W-1:0] dm_streak;

    // After MAX_DM_STREAK back-to-back DM wins over a waiting fetch, fetch gets one slot.
    assign fair_force = if_req && (dm_streak == STREAK_W'(MAX_DM_STREAK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dm_streak <= '0;
        end else if (dm_gnt && if_req) begin
            dm_streak <= dm_streak + STREAK_W'(1);
        end else begin
            dm_streak <= '0;
        end
    end
`else
    assign fair_force = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RVEC;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        ivec_ack  = 1'b0;
        pc_load   = 1'b0;
        pc_vec    = '0;
        mem_addr  = if_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        // Outputs are gated by rst directly so a write in flight dies the instant reset asserts.
        if (!rst) begin
            mem_addr = '0;
        end else begin
            case (state)
                RVEC: begin
                    mem_addr  = ADDR_W'(RST_VEC_ADDR);
                    pc_load   = 1'b1;
                    pc_vec    = mem_rdata;
                    state_nxt = RUN;
                end
                IVEC: begin
                    mem_addr  = ADDR_W'(INT_VEC_ADDR);
                    pc_load   = 1'b1;
                    ivec_ack  = 1'b1;
                    pc_vec    = mem_rdata;
                    state_nxt = RUN;
                end
                default: begin
                    if (fair_force) begin
                        if_gnt = 1'b1;
                    end else if (dm_req) begin
                        dm_gnt    = 1'b1;
                        mem_addr  = dm_addr;
                        mem_we    = dm_we;
                        mem_wdata = dm_wdata;
                    end else if (ivec_req) begin
                        state_nxt = IVEC;
                    end else if (if_req) begin
                        if_gnt = 1'b1;
                    end
                end
            endcase
        end
    end

    assign if_stall = rst & if_req & ~if_gnt;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a rule-level reference model.
module tb_mem_port_arbiter;

    localparam int MAXS = 4;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif
    localparam int GR_NONE = 0;
    localparam int GR_DM   = 1;
    localparam int GR_IF   = 2;
    localparam int GO_VEC  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       if_req, if_gnt, if_stall;
    logic [7:0] if_addr;
    logic       dm_req, dm_we, dm_gnt;
    logic [7:0] dm_addr, dm_wdata;
    logic       ivec_req, ivec_ack, pc_load;
    logic [7:0] pc_vec, mem_addr, mem_wdata, mem_rdata;
    logic       mem_we;

    logic [7:0] mem [256];
    logic       bk_we;
    logic [7:0] bk_addr, bk_dat;

    logic [7:0] ref_mem [256];
    bit         m_first;
    bit         m_vec;
    int         m_streak;
    int         checks = 0;
    int         errors = 0;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .ivec_req(ivec_req), .ivec_ack(ivec_ack), .pc_load(pc_load), .pc_vec(pc_vec),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) begin
        if (bk_we) mem[bk_addr] <= bk_dat;
        else if (mem_we) mem[mem_addr] <= mem_wdata;
    end

    // Who wins the port in an ordinary running cycle.
    function automatic int decide();
        if (FAIR && if_req && m_streak >= MAXS) return GR_IF;
        if (dm_req) return GR_DM;
        if (ivec_req) return GO_VEC;
        if (if_req) return GR_IF;
        return GR_NONE;
    endfunction

    function automatic logic [29:0] exp_vec();
        logic       ig, st, dg, ack, pl, we;
        logic [7:0] pv, ad, wd;
        ig = 0; st = 0; dg = 0; ack = 0; pl = 0; we = 0; pv = 0; ad = if_addr; wd = 0;
        if (!rst) begin
            ad = 8'h00;
        end else if (m_first) begin
            ad = 8'h00; pl = 1; pv = ref_mem[0];
        end else if (m_vec) begin
            ad = 8'h01; pl = 1; ack = 1; pv = ref_mem[1];
        end else begin
            case (decide())
                GR_DM: begin dg = 1; ad = dm_addr; we = dm_we; wd = dm_we ? dm_wdata : 8'h00; end
                GR_IF: ig = 1;
                default: ;
            endcase
        end
        st = rst & if_req & ~ig;
        return {ig, st, dg, ack, pl, we, pv, ad, wd};
    endfunction

    function automatic logic [29:0] obs_vec();
        return {if_gnt, if_stall, dm_gnt, ivec_ack, pc_load, mem_we,
                pc_load ? pc_vec : 8'h00, mem_addr, mem_we ? mem_wdata : 8'h00};
    endfunction

    function automatic void model_step();
        int d;
        if (!rst) begin
            m_first = 1; m_vec = 0; m_streak = 0;
        end else if (m_first || m_vec) begin
            m_first = 0; m_vec = 0; m_streak = 0;
        end else begin
            d = decide();
            m_vec = (d == GO_VEC);
            m_streak = (d == GR_DM && if_req) ? m_streak + 1 : 0;
            if (d == GR_DM && dm_we) ref_mem[dm_addr] = dm_wdata;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive_idle();
        if_req = 0; dm_req = 0; dm_we = 0; ivec_req = 0;
    endtask

    task automatic test_reset();
        logic [29:0] o, e;
        for (int i = 0; i < 256; i++) begin
            bk_we = 1; bk_addr = 8'(i);
            bk_dat = (i == 0) ? 8'h02 : 8'($urandom);
            ref_mem[i] = bk_dat;
            if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
            ivec_req = 1'($urandom); if_addr = 8'($urandom); dm_addr = 8'($urandom);
            dm_wdata = 8'($urandom);
            @(negedge clk);
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e || mem_addr !== 8'h00) begin
                errors++;
                $display("FAIL reset_outputs i=%0d: got %h required %h", i, o, e);
            end
            tick();
        end
        bk_we = 0;
    endtask

    task automatic test_reset_vector();
        logic [29:0] o, e;
        drive_idle(); if_req = 1; if_addr = 8'h02; rst = 1;
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || pc_load !== 1'b1 || pc_vec !== 8'h02 || mem_addr !== 8'h00 || if_gnt !== 1'b0) begin
            errors++;
            $display("FAIL rvec_cycle: got %h (pc_vec=%h addr=%h) required %h", o, pc_vec, mem_addr, e);
        end
        tick();
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || if_gnt !== 1'b1 || mem_addr !== 8'h02) begin
            errors++;
            $display("FAIL rvec_first_fetch: got %h (if_gnt=%b addr=%h) required %h", o, if_gnt, mem_addr, e);
        end
        tick();
    endtask

    task automatic test_conflict();
        logic [29:0] o, e;
        if_req = 1; if_addr = 8'h05; dm_req = 1; dm_we = 1; dm_addr = 8'h80; dm_wdata = 8'h3C;
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || dm_gnt !== 1'b1 || if_stall !== 1'b1 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL conflict_dm_wins: got %h required %h", o, e);
        end
        tick();
        checks++;
        if (mem[8'h80] !== 8'h3C) begin
            errors++;
            $display("FAIL conflict_write: M[80]=%h required 3c", mem[8'h80]);
        end
        dm_req = 0; dm_we = 0;
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || if_gnt !== 1'b1 || mem_addr !== 8'h05) begin
            errors++;
            $display("FAIL conflict_if_after: got %h required %h", o, e);
        end
        tick();
    endtask

    task automatic test_interrupt();
        logic [29:0] o, e;
        drive_idle(); dm_req = 1; dm_we = 1; dm_addr = 8'h01; dm_wdata = 8'h40;
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e) begin errors++; $display("FAIL int_setup: got %h required %h", o, e); end
        tick();
        ivec_req = 1; dm_we = 0; if_req = 1; if_addr = 8'h10;
        for (int k = 0; k < 2; k++) begin
            dm_addr = 8'($urandom);
            @(negedge clk);
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e || dm_gnt !== 1'b1 || ivec_ack !== 1'b0) begin
                errors++;
                $display("FAIL int_dm_burst k=%0d: got %h required %h", k, o, e);
            end
            tick();
        end
        dm_req = 0;
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || if_gnt !== 1'b0 || dm_gnt !== 1'b0 || if_stall !== 1'b1) begin
            errors++;
            $display("FAIL int_decide: got %h required %h", o, e);
        end
        tick();
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || ivec_ack !== 1'b1 || pc_load !== 1'b1 || pc_vec !== 8'h40 || mem_addr !== 8'h01) begin
            errors++;
            $display("FAIL int_vector: got %h (pc_vec=%h) required %h", o, pc_vec, e);
        end
        tick();
        ivec_req = 0;
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || if_gnt !== 1'b1 || ivec_ack !== 1'b0) begin
            errors++;
            $display("FAIL int_resume: got %h required %h", o, e);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [29:0] o, e;
        string pat, want;
        pat = "";
        want = FAIR ? "DDDDIDDDDI" : "DDDDDDDDDD";
        drive_idle(); dm_req = 1; if_req = 1; if_addr = 8'h22;
        for (int k = 0; k < 10; k++) begin
            dm_addr = 8'($urandom);
            @(negedge clk);
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL fair_cycle k=%0d: got %h required %h", k, o, e);
            end
            pat = {pat, dm_gnt ? "D" : (if_gnt ? "I" : "-")};
            tick();
        end
        checks++;
        if (pat != want) begin
            errors++;
            $display("FAIL fair_pattern: got %s required %s", pat, want);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [29:0] o, e;
        int bad;
        for (int k = 0; k < 600; k++) begin
            rst = ($urandom_range(0, 59) != 0);
            if_req = ($urandom_range(0, 3) != 0);
            dm_req = ($urandom_range(0, 2) == 0);
            dm_we = 1'($urandom);
            ivec_req = ($urandom_range(0, 5) == 0);
            if_addr = 8'($urandom); dm_addr = 8'($urandom); dm_wdata = 8'($urandom);
            if (k % 50 == 7) dm_addr = 8'hFF;
            @(negedge clk);
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random k=%0d: got %h required %h", k, o, e);
            end
            tick();
        end
        rst = 1; drive_idle();
        @(negedge clk);
        tick();
        @(negedge clk);
        tick();
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL random_mem_image: %0d words differ, required 0", bad);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [29:0] o, e;
        logic [7:0] old;
        old = ref_mem[8'h90];
        drive_idle(); dm_req = 1; dm_we = 1; dm_addr = 8'h90; dm_wdata = ~old;
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL midwr_before: got %h required %h", o, e);
        end
        #2 rst = 0;
        #1;
        checks++;
        if (mem_we !== 1'b0 || dm_gnt !== 1'b0 || mem_addr !== 8'h00) begin
            errors++;
            $display("FAIL midwr_drop: we=%b gnt=%b addr=%h required 0 0 00", mem_we, dm_gnt, mem_addr);
        end
        tick();
        checks++;
        if (mem[8'h90] !== old) begin
            errors++;
            $display("FAIL midwr_mem: M[90]=%h required %h", mem[8'h90], old);
        end
        drive_idle(); rst = 1; if_req = 1; if_addr = 8'h33;
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || pc_load !== 1'b1 || mem_addr !== 8'h00 || pc_vec !== ref_mem[0]) begin
            errors++;
            $display("FAIL midwr_rvec: got %h required %h", o, e);
        end
        tick();
        @(negedge clk);
        o = obs_vec(); e = exp_vec();
        checks++;
        if (o !== e || if_gnt !== 1'b1 || mem_addr !== 8'h33) begin
            errors++;
            $display("FAIL midwr_resume: got %h required %h", o, e);
        end
        tick();
    endtask

    task automatic test_idle();
        logic [29:0] o, e;
        drive_idle();
        for (int k = 0; k < 8; k++) begin
            if_addr = 8'($urandom); dm_addr = 8'($urandom); dm_wdata = 8'($urandom);
            @(negedge clk);
            o = obs_vec(); e = exp_vec();
            checks++;
            if (o !== e || mem_we !== 1'b0 || pc_load !== 1'b0 || if_gnt !== 1'b0 ||
                dm_gnt !== 1'b0 || mem_addr !== if_addr) begin
                errors++;
                $display("FAIL idle k=%0d: got %h required %h", k, o, e);
            end
            tick();
        end
    endtask

    initial begin
        rst = 0; bk_we = 0; bk_addr = 0; bk_dat = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0;
        drive_idle();
        m_first = 1; m_vec = 0; m_streak = 0;
        test_reset();
        test_reset_vector();
        test_conflict();
        test_interrupt();
        test_fairness();
        test_idle();
        test_random();
        test_reset_mid_write();
        test_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
